// File: rtl/aes_pkg.sv
// Shared definitions for the AES peripheral datapath: ULA function codes,
// register and bus selectors, control-word field positions and handshake states.
package aes_pkg;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    XOR_busAbusB  = 2'b00,
    INC_busA      = 2'b01,
    MOV_busA_busR = 2'b10,
    ZERO_busR     = 2'b11
  } fs_e;

  typedef enum logic [1:0] {
    REG_R0 = 2'd0,
    REG_R1 = 2'd1,
    REG_R2 = 2'd2,
    REG_R3 = 2'd3
  } reg_e;

  typedef enum logic {
    bus_ULA = 1'b0,
    bus_AES = 1'b1
  } bus_e;

  // Control word layout: {SEL_busA, SEL_busB, SEL_busR, reg_DEST, start_AES, decrypt, FS}
  localparam int CW_SEL_A_HI = 10;
  localparam int CW_SEL_A_LO = 9;
  localparam int CW_SEL_B_HI = 8;
  localparam int CW_SEL_B_LO = 7;
  localparam int CW_SEL_R    = 6;
  localparam int CW_DEST_HI  = 5;
  localparam int CW_DEST_LO  = 4;
  localparam int CW_START    = 3;
  localparam int CW_DECRYPT  = 2;
  localparam int CW_FS_HI    = 1;
  localparam int CW_FS_LO    = 0;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_WAIT  = 2'd1,
    A_DONE  = 2'd2,
    A_DRAIN = 2'd3
  } aes_state_e;
endpackage

// File: rtl/aes_ula.sv
// Combinational ULA of the AES datapath: XOR, increment, move or clear.
module aes_ula
  import aes_pkg::*;
(
  input  logic [DATA_W-1:0] bus_a,
  input  logic [DATA_W-1:0] bus_b,
  input  logic [1:0]        fs,
  output logic [DATA_W-1:0] result
);
  always_comb begin
    result = '0;
    case (fs)
      XOR_busAbusB:  result = bus_a ^ bus_b;
      INC_busA:      result = bus_a + 128'd1;
      MOV_busA_busR: result = bus_a;
      default:       result = '0;
    endcase
  end
endmodule

// File: rtl/aes_datapath.sv
// AES peripheral datapath: four working registers, ULA, result bus and the
// start/done handshake toward the cipher core. Host port writes only while enable_amba.
module aes_datapath
  import aes_pkg::*;
(
  input  logic         ACLK,
  input  logic         ARSTn,
  input  logic         enable_amba,
  input  logic         host_wr_en,
  input  logic [1:0]   host_wr_sel,
  input  logic [127:0] host_wr_data,
  input  logic [1:0]   rd_sel,
  output logic [127:0] rd_data,
  input  logic [10:0]  control_word,
  input  logic         wr_control,
  output logic         valid_AES,
  output logic         aes_start,
  output logic         aes_decrypt,
  output logic [127:0] aes_din,
  input  logic [127:0] aes_dout,
  input  logic         aes_done,
  output logic [1:0]   dbg_aes_state
);
  logic [1:0] sel_a, sel_b, dest, fs;
  logic       sel_r, start_aes, decrypt;

  assign sel_a     = control_word[CW_SEL_A_HI:CW_SEL_A_LO];
  assign sel_b     = control_word[CW_SEL_B_HI:CW_SEL_B_LO];
  assign sel_r     = control_word[CW_SEL_R];
  assign dest      = control_word[CW_DEST_HI:CW_DEST_LO];
  assign start_aes = control_word[CW_START];
  assign decrypt   = control_word[CW_DECRYPT];
  assign fs        = control_word[CW_FS_HI:CW_FS_LO];

  logic [DATA_W-1:0] r_q [4];
  logic [DATA_W-1:0] r_d [4];
  logic [DATA_W-1:0] bus_a, bus_b, ula_out, bus_r;
  logic [DATA_W-1:0] aes_res_q, aes_res_d;

  assign bus_a   = r_q[sel_a];
  assign bus_b   = r_q[sel_b];
  assign rd_data = r_q[rd_sel];
  assign bus_r   = (sel_r == bus_AES) ? aes_res_q : ula_out;

  aes_ula u_ula (
    .bus_a  (bus_a),
    .bus_b  (bus_b),
    .fs     (fs),
    .result (ula_out)
  );

  // The controller port has priority over the host port on the same edge.
  always_comb begin
    r_d = r_q;
    if (wr_control) begin
      r_d[dest] = bus_r;
    end else if (host_wr_en && enable_amba) begin
      r_d[host_wr_sel] = host_wr_data;
    end
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  // Handshake: aes_start is a single-cycle request carrying aes_din/aes_decrypt;
  // the core answers with a single-cycle aes_done qualifying aes_dout. Only one
  // request is outstanding; a done after the controller gave up is drained.
  aes_state_e        state_q, state_d;
  logic              start_q, start_d;
  logic              dec_q, dec_d;
  logic              valid_q, valid_d;
  logic              wait_low_q, wait_low_d;
  logic [DATA_W-1:0] din_q, din_d;

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    dec_d      = dec_q;
    valid_d    = valid_q;
    wait_low_d = wait_low_q;
    din_d      = din_q;
    aes_res_d  = aes_res_q;
    case (state_q)
      A_IDLE: begin
        // After a drained request, start_AES must be seen low before re-arming.
        if (!start_aes) wait_low_d = 1'b0;
        if (start_aes && !wait_low_q) begin
          state_d = A_WAIT;
          start_d = 1'b1;
          din_d   = bus_b;
          dec_d   = decrypt;
        end
      end
      A_WAIT: begin
        if (aes_done) begin
          state_d   = A_DONE;
          aes_res_d = aes_dout;
          valid_d   = 1'b1;
        end else if (!start_aes) begin
          state_d = A_DRAIN;
        end
      end
      A_DONE: begin
        if (!start_aes) begin
          state_d = A_IDLE;
          valid_d = 1'b0;
        end
      end
      A_DRAIN: begin
        if (aes_done) begin
          state_d    = A_IDLE;
          wait_low_d = 1'b1;
        end
      end
      default: state_d = A_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q    <= A_IDLE;
      start_q    <= 1'b0;
      dec_q      <= 1'b0;
      valid_q    <= 1'b0;
      wait_low_q <= 1'b0;
      din_q      <= '0;
      aes_res_q  <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      dec_q      <= dec_d;
      valid_q    <= valid_d;
      wait_low_q <= wait_low_d;
      din_q      <= din_d;
      aes_res_q  <= aes_res_d;
    end
  end

  assign aes_start     = start_q;
  assign aes_decrypt   = dec_q;
  assign aes_din       = din_q;
  assign valid_AES     = valid_q;
  assign dbg_aes_state = state_q;
endmodule

// File: tb/tb_aes_datapath.sv
// Bench for aes_datapath: transaction-level reference model, a per-cycle
// compare process, directed scenarios with literal expectations and random traffic.
module tb_aes_datapath;
  logic         ACLK = 1'b0;
  logic         ARSTn = 1'b0;
  logic         enable_amba = 1'b0;
  logic         host_wr_en = 1'b0;
  logic [1:0]   host_wr_sel = 2'd0;
  logic [127:0] host_wr_data = '0;
  logic [1:0]   rd_sel = 2'd0;
  logic [127:0] rd_data;
  logic [10:0]  control_word = '0;
  logic         wr_control = 1'b0;
  logic         valid_AES;
  logic         aes_start;
  logic         aes_decrypt;
  logic [127:0] aes_din;
  logic [127:0] aes_dout = '0;
  logic         aes_done = 1'b0;
  logic [1:0]   dbg_aes_state;

  int checks = 0;
  int errors = 0;

  aes_datapath dut (
    .ACLK          (ACLK),
    .ARSTn         (ARSTn),
    .enable_amba   (enable_amba),
    .host_wr_en    (host_wr_en),
    .host_wr_sel   (host_wr_sel),
    .host_wr_data  (host_wr_data),
    .rd_sel        (rd_sel),
    .rd_data       (rd_data),
    .control_word  (control_word),
    .wr_control    (wr_control),
    .valid_AES     (valid_AES),
    .aes_start     (aes_start),
    .aes_decrypt   (aes_decrypt),
    .aes_din       (aes_din),
    .aes_dout      (aes_dout),
    .aes_done      (aes_done),
    .dbg_aes_state (dbg_aes_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] cw(input logic [1:0] a, input logic [1:0] b, input logic r,
                                     input logic [1:0] d, input logic s, input logic dec,
                                     input logic [1:0] fs);
    return {a, b, r, d, s, dec, fs};
  endfunction

  // Toy cipher: encrypt swaps halves, decrypt inverts.
  function automatic logic [127:0] cipher(input logic [127:0] x, input logic dec);
    return dec ? ~x : {x[63:0], x[127:64]};
  endfunction

  function automatic logic [127:0] rand128();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return 128'(($urandom_range(0, 3)));
      default: return {$urandom, $urandom, $urandom, $urandom};
    endcase
  endfunction

  // ---------------- cipher core model ----------------
  int           core_lat = 10;
  int           core_cnt = 0;
  logic         spurious_en = 1'b0;
  logic [127:0] core_res = '0;

  initial begin
    forever begin
      @(posedge ACLK); #1;
      aes_done = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          aes_done = 1'b1;
          aes_dout = core_res;
        end
      end else if (spurious_en && $urandom_range(0, 15) == 0) begin
        aes_done = 1'b1;
        aes_dout = {$urandom, $urandom, $urandom, $urandom};
      end
      if (aes_start) begin
        core_cnt = core_lat;
        core_res = cipher(aes_din, aes_decrypt);
      end
    end
  end

  // ---------------- reference model ----------------
  // Transaction view: a request is "owed" a done by the core; the controller may
  // "abandon" it; a finished result is "held" until start_AES falls.
  logic [127:0] m_r [4] = '{default: '0};
  logic [127:0] m_res = '0, m_din = '0;
  logic         m_dec = 1'b0, m_start = 1'b0, m_held = 1'b0;
  logic         owed = 1'b0, abandoned = 1'b0, must_low = 1'b0;
  logic [127:0] m_a, m_b, m_u, m_busr;
  logic         st;

  always @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      for (int i = 0; i < 4; i++) m_r[i] = '0;
      m_res = '0; m_din = '0; m_dec = 1'b0; m_start = 1'b0; m_held = 1'b0;
      owed = 1'b0; abandoned = 1'b0; must_low = 1'b0;
    end else begin
      m_a = m_r[control_word[10:9]];
      m_b = m_r[control_word[8:7]];
      case (control_word[1:0])
        2'd0:    m_u = m_a ^ m_b;
        2'd1:    m_u = m_a + 128'd1;
        2'd2:    m_u = m_a;
        default: m_u = '0;
      endcase
      m_busr = control_word[6] ? m_res : m_u;
      st = control_word[3];
      if (wr_control) m_r[control_word[5:4]] = m_busr;
      else if (host_wr_en && enable_amba) m_r[host_wr_sel] = host_wr_data;
      m_start = 1'b0;
      if (m_held) begin
        if (!st) m_held = 1'b0;
      end else if (owed && !abandoned) begin
        if (aes_done) begin
          owed = 1'b0; m_res = aes_dout; m_held = 1'b1;
        end else if (!st) begin
          abandoned = 1'b1;
        end
      end else if (owed) begin
        if (aes_done) begin
          owed = 1'b0; abandoned = 1'b0; must_low = 1'b1;
        end
      end else begin
        if (st && !must_low) begin
          owed = 1'b1; m_start = 1'b1; m_din = m_b; m_dec = control_word[2];
        end
        if (!st) must_low = 1'b0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge ACLK) begin
    chk("valid_AES", 128'(valid_AES), 128'(m_held));
    chk("aes_start", 128'(aes_start), 128'(m_start));
    chk("aes_decrypt", 128'(aes_decrypt), 128'(m_dec));
    chk("aes_din", aes_din, m_din);
    chk("rd_data", rd_data, m_r[rd_sel]);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic host_wr(input logic [1:0] sel, input logic [127:0] data, input logic en);
    enable_amba = en; host_wr_en = 1'b1; host_wr_sel = sel; host_wr_data = data;
    tick();
    host_wr_en = 1'b0; enable_amba = 1'b0;
  endtask

  task automatic ctrl_wr(input logic [10:0] c);
    control_word = c; wr_control = 1'b1;
    tick();
    wr_control = 1'b0;
  endtask

  task automatic expect_reg(input string name, input logic [1:0] sel, input logic [127:0] exp);
    rd_sel = sel;
    @(negedge ACLK);
    chk(name, rd_data, exp);
    tick();
  endtask

  task automatic wait_start(input string name, input logic [127:0] exp_din, input logic exp_dec);
    logic seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (aes_start) begin
        seen = 1'b1;
        chk({name, "_din"}, aes_din, exp_din);
        chk({name, "_dec"}, 128'(aes_decrypt), 128'(exp_dec));
      end
    end
    chk({name, "_start_seen"}, 128'(seen), 128'd1);
  endtask

  task automatic wait_valid(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (valid_AES) seen = 1'b1;
    end
    chk({name, "_valid_seen"}, 128'(seen), 128'd1);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [127:0] P     = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] C_ENC = 128'h8899aabb_ccddeeff_00112233_44556677;
  localparam logic [127:0] C_DEC = 128'hffeeddcc_bbaa9988_77665544_33221100;
  localparam logic [127:0] R0_X  = 128'h00ff00ff_00ff00ff_00ff00ff_00ff00ff;
  localparam logic [127:0] R1_X  = 128'hffffffff_ffffffff_00000000_00000000;
  localparam logic [127:0] XOR_X = 128'hff00ff00_ff00ff00_00ff00ff_00ff00ff;

  logic start_lvl;

  initial begin
    // Reset with inputs toggling.
    spurious_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      enable_amba = 1'($urandom); host_wr_en = 1'($urandom); host_wr_sel = 2'($urandom);
      host_wr_data = rand128(); control_word = 11'($urandom); wr_control = 1'($urandom);
    end
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      @(negedge ACLK);
      chk("reset_rd_data", rd_data, '0);
      chk("reset_outputs", 128'({valid_AES, aes_start, aes_decrypt}), '0);
      chk("reset_aes_din", aes_din, '0);
    end
    spurious_en = 1'b0; enable_amba = 1'b0; host_wr_en = 1'b0;
    control_word = '0; wr_control = 1'b0;
    tick();
    ARSTn = 1'b1;
    tick();

    // XOR path.
    host_wr(2'd0, R0_X, 1'b1);
    host_wr(2'd1, R1_X, 1'b1);
    ctrl_wr(cw(2'd1, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, 2'b00));
    expect_reg("xor_r2", 2'd2, XOR_X);

    // INC wrap.
    host_wr(2'd3, '1, 1'b1);
    ctrl_wr(cw(2'd3, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0, 2'b01));
    expect_reg("inc_wrap_r3", 2'd3, '0);
    ctrl_wr(cw(2'd3, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0, 2'b01));
    expect_reg("inc_one_r3", 2'd3, 128'd1);

    // Collisions: disabled host port, then host vs controller on r2.
    host_wr(2'd1, 128'hdead, 1'b0);
    expect_reg("host_disabled_r1", 2'd1, R1_X);
    enable_amba = 1'b1; host_wr_en = 1'b1; host_wr_sel = 2'd2; host_wr_data = 128'hbeef;
    ctrl_wr(cw(2'd0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, 2'b10));
    host_wr_en = 1'b0; enable_amba = 1'b0;
    expect_reg("collision_r2", 2'd2, R0_X);

    // ECB encrypt.
    core_lat = 10;
    host_wr(2'd0, P, 1'b1);
    control_word = cw(2'd0, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0, 2'b00);
    wait_start("ecb", P, 1'b0);
    wait_valid("ecb");
    tick(); tick();
    ctrl_wr(cw(2'd0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 2'b00));
    expect_reg("ecb_r2", 2'd2, C_ENC);

    // Abort: drop start mid-flight; late done must not replace aes_res.
    host_wr(2'd1, 128'h1, 1'b1);
    control_word = cw(2'd0, 2'd1, 1'b1, 2'd3, 1'b1, 1'b0, 2'b00);
    wait_start("abort", 128'h1, 1'b0);
    tick(); tick();
    control_word = cw(2'd0, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0, 2'b00);
    repeat (14) tick();
    ctrl_wr(cw(2'd0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, 2'b00));
    expect_reg("abort_res_kept", 2'd3, C_ENC);

    // Normal decrypt after the abort.
    control_word = cw(2'd0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b1, 2'b00);
    wait_start("dec", P, 1'b1);
    wait_valid("dec");
    ctrl_wr(cw(2'd0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 2'b00));
    expect_reg("dec_r1", 2'd1, C_DEC);

    // Reset mid-operation; the late done after release is ignored.
    control_word = cw(2'd0, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0, 2'b00);
    wait_start("rst_mid", P, 1'b0);
    tick();
    ARSTn = 1'b0;
    control_word = '0;
    tick(); tick();
    ARSTn = 1'b1;
    repeat (12) tick();
    ctrl_wr(cw(2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00));
    expect_reg("rst_mid_res_zero", 2'd0, '0);

    // Random traffic against the model.
    spurious_en = 1'b1;
    start_lvl = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) start_lvl = ~start_lvl;
      control_word = cw(2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
                        start_lvl, 1'($urandom), 2'($urandom));
      wr_control   = ($urandom_range(0, 3) == 0);
      enable_amba  = 1'($urandom);
      host_wr_en   = 1'($urandom);
      host_wr_sel  = 2'($urandom);
      host_wr_data = rand128();
      rd_sel       = 2'($urandom);
      core_lat     = $urandom_range(1, 8);
      tick();
    end
    wr_control = 1'b0; host_wr_en = 1'b0; control_word = '0;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
